// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
//   Shared definitions for the vending controller:
//     - state_e      : controller state encoding (IDLE / COLLECT / DONE)
//     - COIN_CODE_*  : coin-acceptor codes carrying value
//     - coin_value   : maps a coin code to its credit value
//     - coin_present : true when the code carries a coin at all
// -----------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // no credit held
        ST_COLLECT = 2'd1,   // 0 < credit < PRICE
        ST_DONE    = 2'd2    // single-cycle lockout after vend/refund
    } state_e;

    // Codes 2'b00 and 2'b01 both mean "no coin".
    localparam logic [1:0] COIN_CODE_A = 2'b10;
    localparam logic [1:0] COIN_CODE_B = 2'b11;

    // Coin values are parameters of the top level, so they are passed in.
    function automatic int unsigned coin_value(input logic [1:0] code,
                                               input int unsigned val_a,
                                               input int unsigned val_b);
        case (code)
            COIN_CODE_A: return val_a;
            COIN_CODE_B: return val_b;
            default:     return 0;
        endcase
    endfunction

    function automatic logic coin_present(input logic [1:0] code);
        return (code == COIN_CODE_A) || (code == COIN_CODE_B);
    endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// -----------------------------------------------------------------------------
// vend_timeout_ctr
//   Inactivity counter for the COLLECT state. Counts enabled cycles and
//   flags the cycle on which the TIMEOUT_CYC-th consecutive enabled cycle
//   is being sampled.
//
//   Ports
//     clk_i     in   clock, rising edge
//     rst_ni    in   asynchronous active-low reset
//     clear_i   in   synchronous clear (has priority over en_i)
//     en_i      in   count this cycle
//     expire_o  out  combinational: en_i and count has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module vend_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 6144
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // expire_o must not depend on clear_i: the top derives clear_i from its
    // next-state decision, which in turn uses expire_o.
    assign expire_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_fsm_param.sv
// -----------------------------------------------------------------------------
// vend_fsm_param
//   Coin-operated vending controller. Accumulates credit from two coin
//   denominations, dispenses at PRICE with change, and refunds the held
//   credit on cancel or after TIMEOUT_CYC coin-free cycles in COLLECT.
//   All outputs are registered.
//
//   Ports
//     clk_i         in   clock, rising edge
//     rst_ni        in   asynchronous active-low reset
//     coin_i        in   2  00/01 none, 10 COIN_A, 11 COIN_B (sampled every edge)
//     cancel_i      in   1  level: refund current credit
//     vend_o        out  1  one-cycle pulse: dispense item
//     refund_o      out  1  one-cycle pulse: credit returned (cancel/timeout)
//     change_vld_o  out  1  one-cycle pulse: change_amt_o valid
//     change_amt_o  out  CREDIT_W change or refund amount, 0 otherwise
//     credit_o      out  CREDIT_W accumulated credit
//     busy_o        out  1  high while in DONE (coins rejected)
//     coin_rej_o    out  1  one-cycle pulse: coin presented but not accepted
//     state_o       out  state_e current controller state (debug)
// -----------------------------------------------------------------------------
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int unsigned PRICE       = 15,
    parameter int unsigned COIN_A      = 5,
    parameter int unsigned COIN_B      = 10,
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned TIMEOUT_CYC = 6144
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          coin_i,
    input  logic                cancel_i,
    output logic                vend_o,
    output logic                refund_o,
    output logic                change_vld_o,
    output logic [CREDIT_W-1:0] change_amt_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                coin_rej_o,
    output state_e              state_o
);

    // One extra bit so credit + coin can never wrap before the PRICE compare.
    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] PRICE_W = SUM_W'(PRICE);

    state_e state_q, state_d;

    logic [CREDIT_W-1:0] credit_q,     credit_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                vend_q,       vend_d;
    logic                refund_q,     refund_d;
    logic                change_vld_q, change_vld_d;
    logic                busy_q,       busy_d;
    logic                coin_rej_q,   coin_rej_d;

    // ------------------------------------------------------------------
    // Decode of the current cycle's events
    // ------------------------------------------------------------------
    logic             has_coin;
    logic [SUM_W-1:0] coin_val;
    logic [SUM_W-1:0] sum;
    logic             accepting;   // coin is credited this cycle
    logic             pay_done;    // accepted coin reaches PRICE
    logic             refund_go;   // cancel or timeout in COLLECT
    logic             tmr_clear;
    logic             tmr_en;
    logic             tmr_expire;

    assign has_coin = coin_present(coin_i);
    assign coin_val = SUM_W'(coin_value(coin_i, COIN_A, COIN_B));
    assign sum      = {1'b0, credit_q} + coin_val;

    // Cancel beats a coin presented in the same cycle.
    assign accepting = has_coin && !cancel_i &&
                       ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
    assign pay_done  = accepting && (sum >= PRICE_W);

    // Timer only counts coin-free, cancel-free COLLECT cycles, so an
    // arriving coin always wins over an expiry in the same cycle.
    assign tmr_en    = (state_q == ST_COLLECT) && !has_coin && !cancel_i;
    assign tmr_clear = (state_q != ST_COLLECT) || accepting;

    assign refund_go = (state_q == ST_COLLECT) && (cancel_i || tmr_expire);

    vend_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    // ------------------------------------------------------------------
    // State register (and registered datapath/outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            credit_q     <= '0;
            change_amt_q <= '0;
            vend_q       <= 1'b0;
            refund_q     <= 1'b0;
            change_vld_q <= 1'b0;
            busy_q       <= 1'b0;
            coin_rej_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_amt_q <= change_amt_d;
            vend_q       <= vend_d;
            refund_q     <= refund_d;
            change_vld_q <= change_vld_d;
            busy_q       <= busy_d;
            coin_rej_q   <= coin_rej_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accepting) begin
                    state_d = pay_done ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (refund_go || pay_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic (values registered at the next edge)
    // ------------------------------------------------------------------
    always_comb begin
        credit_d     = credit_q;
        change_amt_d = '0;
        vend_d       = 1'b0;
        refund_d     = 1'b0;
        change_vld_d = 1'b0;
        coin_rej_d   = 1'b0;
        busy_d       = (state_d == ST_DONE);

        // Any coin not credited is flagged: lockout, or lost to a cancel.
        if (has_coin && !accepting) begin
            coin_rej_d = 1'b1;
        end

        if (refund_go) begin
            refund_d     = 1'b1;
            change_vld_d = 1'b1;
            change_amt_d = credit_q;
            credit_d     = '0;
        end else if (pay_done) begin
            vend_d       = 1'b1;
            change_amt_d = CREDIT_W'(sum - PRICE_W);
            change_vld_d = (sum != PRICE_W);
            credit_d     = '0;
        end else if (accepting) begin
            credit_d     = sum[CREDIT_W-1:0];
        end
    end

    assign vend_o       = vend_q;
    assign refund_o     = refund_q;
    assign change_vld_o = change_vld_q;
    assign change_amt_o = change_amt_q;
    assign credit_o     = credit_q;
    assign busy_o       = busy_q;
    assign coin_rej_o   = coin_rej_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
module tb_vend_fsm_param;
    import vend_pkg::*;

    localparam int unsigned PRICE       = 15;
    localparam int unsigned COIN_A      = 5;
    localparam int unsigned COIN_B      = 10;
    localparam int unsigned CREDIT_W    = 5;
    localparam int unsigned TIMEOUT_CYC = 6144;
    localparam int          EW          = 3 + 2 * CREDIT_W + 2;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_A    = 2'b10;
    localparam logic [1:0] C_B    = 2'b11;

    logic                clk_i;
    logic                rst_ni;
    logic [1:0]          coin_i;
    logic                cancel_i;
    logic                vend_o;
    logic                refund_o;
    logic                change_vld_o;
    logic [CREDIT_W-1:0] change_amt_o;
    logic [CREDIT_W-1:0] credit_o;
    logic                busy_o;
    logic                coin_rej_o;
    state_e              state_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: one expected output vector per clocked cycle.
    // Layout {vend, refund, change_vld, change_amt, credit, busy, coin_rej}.
    logic [EW-1:0] exp_q[$];

    // Reference model state: plain credit amount, lockout flag, quiet count.
    int m_credit;
    int m_quiet;
    bit m_lock;

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    vend_fsm_param #(
        .PRICE       (PRICE),
        .COIN_A      (COIN_A),
        .COIN_B      (COIN_B),
        .CREDIT_W    (CREDIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .coin_i       (coin_i),
        .cancel_i     (cancel_i),
        .vend_o       (vend_o),
        .refund_o     (refund_o),
        .change_vld_o (change_vld_o),
        .change_amt_o (change_amt_o),
        .credit_o     (credit_o),
        .busy_o       (busy_o),
        .coin_rej_o   (coin_rej_o),
        .state_o      (state_o)
    );

    function automatic logic [EW-1:0] obs_vec();
        return {vend_o, refund_o, change_vld_o, change_amt_o, credit_o, busy_o, coin_rej_o};
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_credit = 0;
        m_quiet  = 0;
        m_lock   = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] c, input logic can);
        int val;
        int amt;
        bit vnd, rfd, vld, rej;
        val = (c == C_A) ? COIN_A : (c == C_B) ? COIN_B : 0;
        amt = 0; vnd = 0; rfd = 0; vld = 0; rej = 0;
        if (m_lock) begin
            rej    = (val != 0);
            m_lock = 1'b0;
        end else if (can) begin
            rej = (val != 0);
            if (m_credit > 0) begin
                rfd = 1; vld = 1; amt = m_credit;
                m_credit = 0; m_lock = 1'b1;
            end
        end else if (val != 0) begin
            if (m_credit + val >= PRICE) begin
                vnd = 1; amt = m_credit + val - PRICE; vld = (amt != 0);
                m_credit = 0; m_lock = 1'b1;
            end else begin
                m_credit = m_credit + val;
                m_quiet  = 0;
            end
        end else if (m_credit > 0) begin
            m_quiet++;
            if (m_quiet == TIMEOUT_CYC) begin
                rfd = 1; vld = 1; amt = m_credit;
                m_credit = 0; m_lock = 1'b1; m_quiet = 0;
            end
        end
        exp_q.push_back({vnd, rfd, vld, CREDIT_W'(amt), CREDIT_W'(m_credit), m_lock, rej});
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic [1:0] c, input logic can);
        @(negedge clk_i);
        coin_i   = c;
        cancel_i = can;
        model_step(c, can);
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0; coin_i = C_NONE; cancel_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (obs_vec() !== '0 || state_o !== ST_IDLE)
            $display("FAIL reset outputs got %h state %0d exp 0 state %0d", obs_vec(), state_o, ST_IDLE);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_exact_pay();
        logic [EW-1:0] e;
        for (int i = 0; i < 3; i++) begin
            apply(C_A, 1'b0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL exact_pay cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
        end
        n_checks++;
        if (vend_o !== 1'b1 || change_vld_o !== 1'b0 || credit_o !== '0 || busy_o !== 1'b1)
            $display("FAIL exact_pay_vend got vend%b vld%b credit%0d busy%b exp vend1 vld0 credit0 busy1",
                     vend_o, change_vld_o, credit_o, busy_o);
        else n_pass++;
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL exact_pay_tail got %h exp %h", obs_vec(), e);
        else n_pass++;
    endtask

    task automatic test_overpay();
        logic [EW-1:0] e;
        logic [1:0] seq [6];
        seq = '{C_A, C_B, C_NONE, C_B, C_B, C_NONE};
        for (int i = 0; i < 6; i++) begin
            apply(seq[i], 1'b0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL overpay cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (vend_o !== 1'b1 || change_vld_o !== 1'b0 || change_amt_o !== '0)
                    $display("FAIL overpay_a_b got vend%b vld%b amt%0d exp vend1 vld0 amt0",
                             vend_o, change_vld_o, change_amt_o);
                else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if (vend_o !== 1'b1 || change_vld_o !== 1'b1 || change_amt_o !== 5'd5)
                    $display("FAIL overpay_b_b got vend%b vld%b amt%0d exp vend1 vld1 amt5",
                             vend_o, change_vld_o, change_amt_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_cancel_coin();
        logic [EW-1:0] e;
        apply(C_A, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL cancel_coin_c1 got %h exp %h", obs_vec(), e); else n_pass++;
        apply(C_A, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL cancel_coin_c2 got %h exp %h", obs_vec(), e); else n_pass++;
        apply(C_B, 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL cancel_coin_c3 got %h exp %h", obs_vec(), e); else n_pass++;
        n_checks++;
        if (refund_o !== 1'b1 || change_amt_o !== 5'd10 || coin_rej_o !== 1'b1 || vend_o !== 1'b0 || credit_o !== '0)
            $display("FAIL cancel_coin_refund got rfd%b amt%0d rej%b vend%b credit%0d exp rfd1 amt10 rej1 vend0 credit0",
                     refund_o, change_amt_o, coin_rej_o, vend_o, credit_o);
        else n_pass++;
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL cancel_coin_tail got %h exp %h", obs_vec(), e); else n_pass++;
    endtask

    task automatic test_done_coin();
        logic [EW-1:0] e;
        logic [1:0] cs [5];
        logic       cn [5];
        cs = '{C_A, C_A, C_A, C_A, C_NONE};
        cn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            apply(cs[i], cn[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL done_coin cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (coin_rej_o !== 1'b1 || credit_o !== '0 || busy_o !== 1'b0)
                    $display("FAIL done_coin_rej got rej%b credit%0d busy%b exp rej1 credit0 busy0",
                             coin_rej_o, credit_o, busy_o);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_vec() !== '0)
            $display("FAIL idle_cancel got %h exp 0", obs_vec());
        else n_pass++;
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL done_coin_tail got %h exp %h", obs_vec(), e); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        for (int i = 0; i < 9; i++) begin
            apply(C_B, 1'b0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL back_to_back cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
        end
        apply(C_NONE, 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL back_to_back_tail got %h exp %h", obs_vec(), e); else n_pass++;
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL back_to_back_tail2 got %h exp %h", obs_vec(), e); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [EW-1:0] e;
        bit vend_seen;
        vend_seen = 0;
        apply(C_A, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL timeout_coin got %h exp %h", obs_vec(), e); else n_pass++;
        for (int i = 0; i < int'(TIMEOUT_CYC); i++) begin
            apply(C_NONE, 1'b0);
            if (vend_o === 1'b1) vend_seen = 1;
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL timeout cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
        end
        n_checks++;
        if (refund_o !== 1'b1 || change_vld_o !== 1'b1 || change_amt_o !== 5'd5 || credit_o !== '0 || vend_seen)
            $display("FAIL timeout_refund got rfd%b vld%b amt%0d credit%0d vend_seen%b exp rfd1 vld1 amt5 credit0 vend_seen0",
                     refund_o, change_vld_o, change_amt_o, credit_o, vend_seen);
        else n_pass++;
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL timeout_tail got %h exp %h", obs_vec(), e); else n_pass++;
    endtask

    task automatic test_timeout_race();
        logic [EW-1:0] e;
        apply(C_A, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL race_coin got %h exp %h", obs_vec(), e); else n_pass++;
        for (int i = 0; i < int'(TIMEOUT_CYC) - 1; i++) begin
            apply(C_NONE, 1'b0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL race cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
        end
        // Coin arrives on the cycle the timer would otherwise expire.
        apply(C_B, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL race_last got %h exp %h", obs_vec(), e); else n_pass++;
        n_checks++;
        if (vend_o !== 1'b1 || refund_o !== 1'b0 || coin_rej_o !== 1'b0)
            $display("FAIL race_coin_wins got vend%b rfd%b rej%b exp vend1 rfd0 rej0", vend_o, refund_o, coin_rej_o);
        else n_pass++;
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL race_tail got %h exp %h", obs_vec(), e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [EW-1:0] e;
        for (int i = 0; i < 2; i++) begin
            apply(C_A, 1'b0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL reset_mid_fill cyc%0d got %h exp %h", i, obs_vec(), e);
            else n_pass++;
        end
        n_checks++;
        if (credit_o !== 5'd10 || state_o !== ST_COLLECT)
            $display("FAIL reset_mid_credit got %0d state %0d exp 10 state %0d", credit_o, state_o, ST_COLLECT);
        else n_pass++;
        @(negedge clk_i);
        coin_i = C_NONE; cancel_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== '0) $display("FAIL reset_mid_async got %h exp 0", obs_vec()); else n_pass++;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (obs_vec() !== '0 || refund_o !== 1'b0 || state_o !== ST_IDLE)
            $display("FAIL reset_mid_hold got %h state %0d exp 0 state %0d", obs_vec(), state_o, ST_IDLE);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        apply(C_NONE, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_vec() !== e) $display("FAIL reset_mid_after got %h exp %h", obs_vec(), e); else n_pass++;
    endtask

    task automatic test_random();
        logic [EW-1:0] e;
        logic [1:0] c;
        logic can;
        int r;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      c = 2'($urandom_range(0, 1));
            else if (r < 8) c = C_A;
            else            c = C_B;
            can = ($urandom_range(0, 15) == 0);
            apply(c, can);
            e = exp_q.pop_front(); n_checks++;
            if (obs_vec() !== e) $display("FAIL random cyc%0d coin%b can%b got %h exp %h", i, c, can, obs_vec(), e);
            else n_pass++;
            n_checks++;
            if (vend_o === 1'b1 && refund_o === 1'b1)
                $display("FAIL random_excl cyc%0d got vend1 rfd1 exp not both", i);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_exact_pay();
        test_overpay();
        test_cancel_coin();
        test_done_coin();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
